// File: rtl/cache_refill_ctrl.sv
// Refill controller for the 4-way set-associative data cache: dirty-victim writeback,
// word-by-word line refill, tag rewrite and MRU update to the pseudo-LRU tracker.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SET_BITS   = 6,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS),
  localparam int unsigned TAG_W     = ADDR_W - SET_BITS - OFF_W - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic [1:0]          lru_replace,
  input  logic                vic_valid,
  input  logic                vic_dirty,
  input  logic [TAG_W-1:0]    vic_tag,
  output logic [1:0]          vic_rd_way,
  output logic [OFF_W-1:0]    vic_rd_idx,
  input  logic [31:0]         vic_rd_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic                fill_we,
  output logic [1:0]          fill_way,
  output logic [SET_BITS-1:0] fill_set,
  output logic [OFF_W-1:0]    fill_idx,
  output logic [31:0]         fill_data,
  output logic                tag_we,
  output logic [1:0]          tag_way,
  output logic [SET_BITS-1:0] tag_set,
  output logic [TAG_W-1:0]    tag_value,
  output logic                lru_enable,
  output logic [1:0]          lru_target,
  output logic                done,
  output logic                busy
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWb   = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StUpd  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [1:0]          way_q, way_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;
  logic                last_word;

  // Byte offset within the line is irrelevant: refill always starts at word 0.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[OFF_W+1:0];

  assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    set_d   = set_q;
    way_d   = way_q;
    vtag_d  = vtag_q;
    case (state_q)
      StIdle: begin
        if (miss_valid) begin
          state_d = (vic_valid && vic_dirty) ? StWb : StRd;
          cnt_d   = '0;
          tag_d   = miss_addr[ADDR_W-1 -: TAG_W];
          set_d   = miss_addr[OFF_W+2 +: SET_BITS];
          way_d   = lru_replace;
          vtag_d  = vic_tag;
        end
      end
      StWb: begin
        if (mem_ack) begin
          cnt_d = last_word ? '0 : cnt_q + 1'b1;
          if (last_word) state_d = StRd;
        end
      end
      StRd: begin
        if (mem_ack) begin
          cnt_d = last_word ? '0 : cnt_q + 1'b1;
          if (last_word) state_d = StUpd;
        end
      end
      StUpd:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tag_q   <= '0;
      set_q   <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      way_q   <= way_d;
      vtag_q  <= vtag_d;
    end
  end

  // Outputs decode straight from state so they fall asynchronously with reset.
  always_comb begin
    miss_ready = (state_q == StIdle);
    busy       = (state_q != StIdle);
    vic_rd_way = '0;
    vic_rd_idx = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = 1'b0;
    fill_way   = '0;
    fill_set   = '0;
    fill_idx   = '0;
    fill_data  = '0;
    tag_we     = 1'b0;
    tag_way    = '0;
    tag_set    = '0;
    tag_value  = '0;
    lru_enable = 1'b0;
    lru_target = '0;
    done       = 1'b0;
    case (state_q)
      StWb: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {vtag_q, set_q, cnt_q, 2'b00};
        vic_rd_way = way_q;
        vic_rd_idx = cnt_q;
        mem_wdata  = vic_rd_data;
      end
      StRd: begin
        mem_req   = 1'b1;
        mem_addr  = {tag_q, set_q, cnt_q, 2'b00};
        fill_we   = mem_ack;
        fill_way  = way_q;
        fill_set  = set_q;
        fill_idx  = cnt_q;
        fill_data = mem_rdata;
      end
      StUpd: begin
        tag_we     = 1'b1;
        tag_way    = way_q;
        tag_set    = set_q;
        tag_value  = tag_q;
        lru_enable = 1'b1;
        lru_target = way_q;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
